// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: occupancy
// states, default field widths, zero constants and per-stage NOP payloads.
package pipe_pkg;

    // Occupancy of a stage register: main slot, then the optional skid slot
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_EXC_W  = 32;
    localparam int unsigned STALL_W    = 32;

    localparam logic [31:0] ZERO_32   = 32'h0000_0000;
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    // addi x0, x0, 0 : the canonical bubble instruction
    localparam logic [31:0] MEM_NOP = 32'h0000_0013;

    // Stage NOP payloads: NOP instruction in the low word, all control fields cleared
    localparam logic [63:0] IFID_NOP  = {32'h0000_0000, MEM_NOP};
    localparam logic [63:0] IDEXE_NOP = {32'h0000_0000, MEM_NOP};
    localparam logic [63:0] EXMEM_NOP = {32'h0000_0000, MEM_NOP};
    localparam logic [63:0] MEMWB_NOP = {32'h0000_0000, MEM_NOP};

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating 32-bit stall counter; cleared only by reset.
module pipe_stall_ctr
    import pipe_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               inc_i,
    output logic [STALL_W-1:0] count_o
);

    logic [STALL_W-1:0] r_count;

    // Count stalled cycles, sticking at the maximum instead of wrapping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= ZERO_32;
        end else if (inc_i && (r_count != STALL_MAX)) begin
            r_count <= r_count + 32'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign count_o = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake,
// optional two-entry skid buffer (SKID=1) and flush-to-NOP.
// Optional feature macro: PIPE_STAGE_PERF_EN adds the stall_cycles_o counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned             PAYLOAD_W     = 64,
    parameter int unsigned             ADDR_W        = DEF_ADDR_W,
    parameter int unsigned             EXC_W         = DEF_EXC_W,
    parameter logic [PAYLOAD_W-1:0]    RESET_PAYLOAD = '0,
    parameter int unsigned             SKID          = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_payload_i,
    input  logic [ADDR_W-1:0]    in_pc_i,
    input  logic [EXC_W-1:0]     in_exc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_payload_o,
    output logic [ADDR_W-1:0]    out_pc_o,
    output logic [EXC_W-1:0]     out_exc_o,
    input  logic                 flush_i
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [STALL_W-1:0]   stall_cycles_o
`endif
);

    localparam bit SKID_EN = (SKID != 0);

    pipe_state_e          r_state;
    pipe_state_e          w_state_nxt;
    logic                 r_valid;
    logic                 r_in_ready;
    logic                 w_in_ready;
    logic                 w_accept;
    logic                 w_fire;
    logic                 w_ld_main_in;
    logic                 w_ld_main_skid;
    logic                 w_ld_skid;

    logic [PAYLOAD_W-1:0] r_main_payload;
    logic [ADDR_W-1:0]    r_main_pc;
    logic [EXC_W-1:0]     r_main_exc;
    logic [PAYLOAD_W-1:0] r_skid_payload;
    logic [ADDR_W-1:0]    r_skid_pc;
    logic [EXC_W-1:0]     r_skid_exc;

    // Skid mode exposes a registered ready; single-register mode lets a
    // draining entry make room in the same cycle.
    assign w_in_ready = SKID_EN ? r_in_ready : (!r_valid || out_ready_i);
    assign w_accept   = in_valid_i && w_in_ready;
    assign w_fire     = r_valid && out_ready_i;

    // Next occupancy and which slot loads from where
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt  = ST_HALF;
                    w_ld_main_in = 1'b1;
                end else begin
                    w_state_nxt  = ST_EMPTY;
                end
            end
            ST_HALF: begin
                if (w_accept && w_fire) begin
                    w_state_nxt  = ST_HALF;
                    w_ld_main_in = 1'b1;
                end else if (w_accept) begin
                    // only reachable with the skid enabled
                    w_state_nxt  = ST_FULL;
                    w_ld_skid    = 1'b1;
                end else if (w_fire) begin
                    w_state_nxt  = ST_EMPTY;
                end else begin
                    w_state_nxt  = ST_HALF;
                end
            end
            ST_FULL: begin
                if (w_fire) begin
                    w_state_nxt    = ST_HALF;
                    w_ld_main_skid = 1'b1;
                end else begin
                    w_state_nxt    = ST_FULL;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Occupancy, valid and ready registers; flush empties the stage
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush_i) begin
            r_state    <= ST_EMPTY;
            r_valid    <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_valid    <= (w_state_nxt != ST_EMPTY);
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // Main slot: loads from input or skid, otherwise holds
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_main_payload <= RESET_PAYLOAD;
            r_main_pc      <= {ADDR_W{1'b0}};
            r_main_exc     <= {EXC_W{1'b0}};
        end else if (flush_i) begin
            r_main_payload <= RESET_PAYLOAD;
            r_main_pc      <= {ADDR_W{1'b0}};
            r_main_exc     <= {EXC_W{1'b0}};
        end else if (w_ld_main_in) begin
            r_main_payload <= in_payload_i;
            r_main_pc      <= in_pc_i;
            r_main_exc     <= in_exc_i;
        end else if (w_ld_main_skid) begin
            r_main_payload <= r_skid_payload;
            r_main_pc      <= r_skid_pc;
            r_main_exc     <= r_skid_exc;
        end else begin
            r_main_payload <= r_main_payload;
            r_main_pc      <= r_main_pc;
            r_main_exc     <= r_main_exc;
        end
    end

    // Skid slot: catches the entry in flight when downstream stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_skid_payload <= RESET_PAYLOAD;
            r_skid_pc      <= {ADDR_W{1'b0}};
            r_skid_exc     <= {EXC_W{1'b0}};
        end else if (flush_i) begin
            r_skid_payload <= RESET_PAYLOAD;
            r_skid_pc      <= {ADDR_W{1'b0}};
            r_skid_exc     <= {EXC_W{1'b0}};
        end else if (w_ld_skid) begin
            r_skid_payload <= in_payload_i;
            r_skid_pc      <= in_pc_i;
            r_skid_exc     <= in_exc_i;
        end else begin
            r_skid_payload <= r_skid_payload;
            r_skid_pc      <= r_skid_pc;
            r_skid_exc     <= r_skid_exc;
        end
    end

    assign in_ready_o    = w_in_ready;
    assign out_valid_o   = r_valid;
    assign out_payload_o = r_main_payload;
    assign out_pc_o      = r_main_pc;
    assign out_exc_o     = r_main_exc;

`ifdef PIPE_STAGE_PERF_EN
    pipe_stall_ctr u_stall_ctr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (r_valid && !out_ready_i),
        .count_o (stall_cycles_o)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid-mode and a single-register instance share the
// stimulus; each is compared every cycle against a queue-based model.
module tb_pipe_stage_reg;

    localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

    typedef struct packed {
        logic [63:0] p;
        logic [31:0] pc;
        logic [31:0] exc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] in_payload = 64'h0;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_exc = 32'h0;

    logic        rdy1, vld1, rdy0, vld0;
    logic [63:0] pay1, pay0;
    logic [31:0] pc1, pc0, exc1, exc0;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall1, stall0;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.PAYLOAD_W(64), .ADDR_W(32), .EXC_W(32),
                     .RESET_PAYLOAD(NOP), .SKID(1)) dut_skid (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_valid_i(in_valid), .in_ready_o(rdy1),
        .in_payload_i(in_payload), .in_pc_i(in_pc), .in_exc_i(in_exc),
        .out_valid_o(vld1), .out_ready_i(out_ready),
        .out_payload_o(pay1), .out_pc_o(pc1), .out_exc_o(exc1),
        .flush_i(flush)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles_o(stall1)
`endif
    );

    pipe_stage_reg #(.PAYLOAD_W(64), .ADDR_W(32), .EXC_W(32),
                     .RESET_PAYLOAD(NOP), .SKID(0)) dut_single (
        .clk_i(clk), .rst_ni(rst_ni),
        .in_valid_i(in_valid), .in_ready_o(rdy0),
        .in_payload_i(in_payload), .in_pc_i(in_pc), .in_exc_i(in_exc),
        .out_valid_o(vld0), .out_ready_i(out_ready),
        .out_payload_o(pay0), .out_pc_o(pc0), .out_exc_o(exc0),
        .flush_i(flush)
`ifdef PIPE_STAGE_PERF_EN
        , .stall_cycles_o(stall0)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int seq   = 0;

    // model state: entries held, and what the output registers show
    ent_t        q1[$];
    ent_t        q0[$];
    ent_t        shown1;
    ent_t        shown0;
    logic [31:0] stall1_m;
    logic [31:0] stall0_m;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("skid_valid",   {63'd0, vld1}, {63'd0, q1.size() > 0});
        check("skid_ready",   {63'd0, rdy1}, {63'd0, q1.size() < 2});
        check("skid_payload", pay1, shown1.p);
        check("skid_pc",      {32'd0, pc1}, {32'd0, shown1.pc});
        check("skid_exc",     {32'd0, exc1}, {32'd0, shown1.exc});
        check("single_valid",   {63'd0, vld0}, {63'd0, q0.size() > 0});
        check("single_ready",   {63'd0, rdy0}, {63'd0, (q0.size() == 0) || out_ready});
        check("single_payload", pay0, shown0.p);
        check("single_pc",      {32'd0, pc0}, {32'd0, shown0.pc});
        check("single_exc",     {32'd0, exc0}, {32'd0, shown0.exc});
`ifdef PIPE_STAGE_PERF_EN
        check("skid_stall",   {32'd0, stall1}, {32'd0, stall1_m});
        check("single_stall", {32'd0, stall0}, {32'd0, stall0_m});
`endif
    endtask

    task automatic model_reset();
        q1.delete();
        q0.delete();
        shown1   = '{NOP, 32'h0, 32'h0};
        shown0   = '{NOP, 32'h0, 32'h0};
        stall1_m = 32'd0;
        stall0_m = 32'd0;
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model at posedge
    task automatic step(input bit iv, input bit ordy, input bit fl, input logic [63:0] pl);
        ent_t e;
        bit   acc1, fire1, acc0, fire0;
        seq++;
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        in_payload = pl;
        in_pc      = $urandom();
        in_exc     = $urandom();
        e = '{in_payload, in_pc, in_exc};
        @(negedge clk);
        compare_all();
        acc1  = iv && (q1.size() < 2);
        fire1 = (q1.size() > 0) && ordy;
        acc0  = iv && ((q0.size() == 0) || ordy);
        fire0 = (q0.size() > 0) && ordy;
        if ((q1.size() > 0) && !ordy && (stall1_m != 32'hFFFF_FFFF)) stall1_m++;
        if ((q0.size() > 0) && !ordy && (stall0_m != 32'hFFFF_FFFF)) stall0_m++;
        @(posedge clk);
        if (fl) begin
            q1.delete();
            shown1 = '{NOP, 32'h0, 32'h0};
            q0.delete();
            shown0 = '{NOP, 32'h0, 32'h0};
        end else begin
            if (fire1) void'(q1.pop_front());
            if (acc1) q1.push_back(e);
            if (q1.size() > 0) shown1 = q1[0];
            if (fire0) void'(q0.pop_front());
            if (acc0) q0.push_back(e);
            if (q0.size() > 0) shown0 = q0[0];
        end
        #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // streaming 1..8 with downstream always ready
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b1, 1'b0, 64'(i));
        repeat (2) step(1'b0, 1'b1, 1'b0, 64'h0);

        // backpressure: 0xA, 0xB fill the skid, 0xC refused, then drain
        step(1'b1, 1'b0, 1'b0, 64'hA);
        step(1'b1, 1'b0, 1'b0, 64'hB);
        step(1'b1, 1'b0, 1'b0, 64'hC);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 64'h0);

        // flush while FULL with 0xC on offer
        step(1'b1, 1'b0, 1'b0, 64'hA);
        step(1'b1, 1'b0, 1'b0, 64'hB);
        step(1'b1, 1'b0, 1'b1, 64'hC);
        repeat (2) step(1'b0, 1'b1, 1'b0, 64'h0);

        // stalls around a flush
        step(1'b1, 1'b0, 1'b0, 64'h11);
        repeat (3) step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        step(1'b1, 1'b0, 1'b0, 64'h12);
        repeat (2) step(1'b0, 1'b0, 1'b0, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'h0);

        // asynchronous reset between edges mid-stream
        step(1'b1, 1'b1, 1'b0, 64'h21);
        step(1'b1, 1'b0, 1'b0, 64'h22);
        step(1'b1, 1'b0, 1'b0, 64'h23);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_skid_valid",   {63'd0, vld1}, 64'd0);
        check("arst_skid_ready",   {63'd0, rdy1}, 64'd1);
        check("arst_skid_payload", pay1, NOP);
        check("arst_skid_pc",      {32'd0, pc1}, 64'd0);
        check("arst_skid_exc",     {32'd0, exc1}, 64'd0);
        check("arst_single_valid", {63'd0, vld0}, 64'd0);
        check("arst_single_ready", {63'd0, rdy0}, 64'd1);
        check("arst_single_payload", pay0, NOP);
        model_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // randomized traffic
        repeat (3000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 19) == 0, {$urandom(), $urandom()});
        end
        repeat (3) step(1'b0, 1'b1, 1'b0, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register: the successor to the fixed EXE→MEM latch, reusable at every stage boundary (IF/ID, ID/EXE, EXE/MEM, MEM/WB). It adds a valid/ready handshake, an optional 2-entry skid buffer that gives full throughput with registered backpressure, and flush-to-NOP with a configurable bubble payload. Each pipeline boundary instantiates one copy with its own payload width.

## Interface
Parameters:
- PAYLOAD_W, 64: width of the packed stage payload (reg/mem/csr fields, concatenated by the instantiator).
- ADDR_W, 32: instruction address width.
- EXC_W, 32: exception/cause vector width.
- RESET_PAYLOAD, '0: payload value driven on reset and flush; the NOP encoding of the stage.
- SKID, 1: 1 = two-entry skid mode with registered in_ready_o; 0 = single-register mode.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  upstream holds a valid entry.
- in_ready_o  output  1  stage can accept this cycle.
- in_payload_i  input  PAYLOAD_W  upstream payload.
- in_pc_i  input  ADDR_W  instruction address of the entry.
- in_exc_i  input  EXC_W  exception vector of the entry.
- out_valid_o  output  1  stage holds a valid entry.
- out_ready_i  input  1  downstream accepts.
- out_payload_o  output  PAYLOAD_W  registered payload.
- out_pc_o  output  ADDR_W  registered instruction address.
- out_exc_o  output  EXC_W  registered exception vector.
- flush_i  input  1  synchronous kill of all held entries (interrupt/branch flush).
- stall_cycles_o  output  32  perf counter; present only with PIPE_STAGE_PERF_EN.

## Operation
- accept = in_valid_i & in_ready_o; fire = out_valid_o & out_ready_i.
- States, SKID=1: EMPTY (main invalid, skid empty), HALF (main valid, skid empty), FULL (both valid).
- EMPTY: accept → HALF, main ← input.
- HALF: accept & fire → HALF, main ← input; accept & !fire → FULL, skid ← input; !accept & fire → EMPTY; otherwise hold.
- FULL: in_ready_o=0, no accept; fire → HALF, main ← skid; otherwise hold.
- in_ready_o = (state != FULL), registered; it is never a function of out_ready_i.
- SKID=0: FULL is unreachable; in_ready_o = !out_valid_o | out_ready_i (combinational); accept loads main.
- Order preserved; no entry duplicated or dropped except by flush.
- While out_valid_o & !out_ready_i, all out_* held stable.
- flush_i has priority over everything: next state EMPTY, payload ← RESET_PAYLOAD, pc ← 0, exc ← 0 in main and skid; an entry offered in the flush cycle is discarded even if in_ready_o=1.
- Main payload/pc/exc registers load only on accept, skid move, flush or reset; otherwise they hold.

## Timing
- Reset (rst_ni=0, asynchronous): state EMPTY, out_valid_o=0, out_payload_o=RESET_PAYLOAD, out_pc_o=0, out_exc_o=0, in_ready_o=1, stall_cycles_o=0.
- Latency: accept in cycle N → out_valid_o=1 in cycle N+1.
- Throughput: one entry per cycle when out_ready_i stays high, in both modes.
- SKID=1: out_ready_i falling asserts backpressure one cycle later; the skid absorbs the in-flight entry.
- Flush in cycle N: out_valid_o=0 and in_ready_o=1 in cycle N+1.
- Reset deasserted mid-transfer: all entries lost; upstream must re-present.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cycles_o counts cycles with out_valid_o & !out_ready_i. It saturates at 32'hFFFF_FFFF, is cleared only by reset and is unaffected by flush.
- Undefined: port and counter absent; zero area.

## Structure
- Shared package pipe_pkg: state enum (EMPTY/HALF/FULL), default widths ADDR_W/EXC_W, ZERO constants, MEM_NOP-derived stage NOP payloads.
- One sub-module: pipe_stall_ctr (saturating 32-bit counter), instantiated only under PIPE_STAGE_PERF_EN.

## Test plan
- Streaming: SKID=1, out_ready_i=1, payloads 1..8 back-to-back → out 1..8 on consecutive cycles, first one cycle after its accept.
- Backpressure: hold out_ready_i=0 after accepting 0xA, 0xB → FULL, in_ready_o=0, out stays 0xA; release → 0xA then 0xB, no loss.
- Flush in FULL, with in_valid_i=1 offering 0xC → next cycle out_valid_o=0, out_payload_o=RESET_PAYLOAD, 0xC never appears.
- Async reset mid-stream: rst_ni low between edges → outputs reach reset values immediately, in_ready_o=1.
- SKID=0: out_ready_i=0 with out_valid_o=1 → in_ready_o=0 in the same cycle; out_ready_i=1 → accept and fire in the same cycle.
- PIPE_STAGE_PERF_EN: 5 stalled cycles → stall_cycles_o=5; a flush in between leaves the count unchanged.
